vertical_motion: RTL and testbench

VERTICAL_MOTION -- requirements
Module: vertical_motion

---
 rtl/vertical_motion.sv | 153 +++++++++++++++
 tb/tb_vertical_motion.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/vertical_motion.sv
// Per-frame vertical physics for a platformer sprite: jump, gravity, landing and ceiling/floor clamps.
// Optional feature: define DOUBLE_JUMP_EN to allow one extra jump while airborne.
module vertical_motion #(
  parameter int HEIGHT   = 30,
  parameter int GROUND_Y = 440,
  parameter int GRAVITY  = 1,
  parameter int JUMP_VEL = 12,
  parameter int MAX_FALL = 10
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              frame_tick,
  input  logic              jump_btn,
  input  logic              touching_platform,
  input  logic [9:0]        land_y,
  input  logic              supported,
  output logic [9:0]        y_pos,
  output logic [9:0]        next_y,
  output logic signed [5:0] vel_y,
  output logic              airborne
);

  localparam int                 REST_Y  = GROUND_Y - 2 * HEIGHT;
  localparam logic [9:0]         REST_YV = 10'(REST_Y);
  localparam logic [9:0]         SPAN_V  = 10'(2 * HEIGHT);
  localparam logic signed [11:0] REST_S  = 12'(REST_Y);
  localparam logic signed [5:0]  JUMP_V  = 6'(-JUMP_VEL);
  localparam logic signed [5:0]  GRAV_V  = 6'(GRAVITY);
  localparam logic signed [6:0]  GRAV7   = 7'(GRAVITY);
  localparam logic signed [6:0]  MAX7    = 7'(MAX_FALL);
  localparam logic signed [5:0]  MAX_V   = 6'(MAX_FALL);

  typedef enum logic [1:0] {GROUNDED, RISING, FALLING} state_t;

  state_t              state, state_nxt;
  logic [9:0]          y_nxt;
  logic signed [5:0]   vel_nxt;
  logic                jump_latch, latch_nxt;
  logic                prev_btn;
  logic                btn_edge, jump_req;
  logic signed [11:0]  sum_y;
  logic                top_clamp, floor_reach;
`ifdef DOUBLE_JUMP_EN
  logic                jump_cnt, cnt_nxt;
`endif

  // Clamp a candidate top line into the visible range between row 0 and the resting row.
  function automatic logic [9:0] clamp_y(input logic signed [11:0] s);
    if (s < 0)
      return 10'd0;
    else if (s > REST_S)
      return REST_YV;
    else
      return s[9:0];
  endfunction

  function automatic logic signed [5:0] sat_vel(input logic signed [5:0] v);
    logic signed [6:0] s;
    s = $signed({v[5], v}) + GRAV7;
    if (s > MAX7)
      return MAX_V;
    else
      return s[5:0];
  endfunction

  assign sum_y       = $signed({2'b00, y_pos}) + $signed({{6{vel_y[5]}}, vel_y});
  assign top_clamp   = (sum_y < 0);
  assign floor_reach = (sum_y >= REST_S);
  assign next_y      = clamp_y(sum_y);
  assign airborne    = (state != GROUNDED);
  assign btn_edge    = jump_btn & ~prev_btn;
  // An edge arriving on the tick cycle itself still counts as a request.
  assign jump_req    = jump_latch | btn_edge;

  always_comb begin
    state_nxt = state;
    y_nxt     = y_pos;
    vel_nxt   = vel_y;
    latch_nxt = jump_req;
`ifdef DOUBLE_JUMP_EN
    cnt_nxt   = jump_cnt;
`endif
    if (frame_tick) begin
      latch_nxt = 1'b0;
      case (state)
        GROUNDED: begin
          if (jump_req) begin
            vel_nxt   = JUMP_V;
            y_nxt     = next_y;
            state_nxt = RISING;
          end else if (!supported) begin
            vel_nxt   = GRAV_V;
            state_nxt = FALLING;
          end
        end
        default: begin
          if (touching_platform && !vel_y[5]) begin
            y_nxt     = land_y - SPAN_V;
            vel_nxt   = '0;
            state_nxt = GROUNDED;
`ifdef DOUBLE_JUMP_EN
            cnt_nxt   = 1'b0;
`endif
          end else if (floor_reach) begin
            y_nxt     = REST_YV;
            vel_nxt   = '0;
            state_nxt = GROUNDED;
`ifdef DOUBLE_JUMP_EN
            cnt_nxt   = 1'b0;
`endif
          end
`ifdef DOUBLE_JUMP_EN
          else if (jump_req && !jump_cnt) begin
            y_nxt     = next_y;
            vel_nxt   = JUMP_V;
            state_nxt = RISING;
            cnt_nxt   = 1'b1;
          end
`endif
          else begin
            y_nxt     = next_y;
            // Hitting the top of the screen kills upward motion immediately.
            vel_nxt   = (top_clamp && state == RISING) ? 6'sd0 : sat_vel(vel_y);
            state_nxt = vel_nxt[5] ? RISING : FALLING;
          end
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= GROUNDED;
      y_pos      <= REST_YV;
      vel_y      <= '0;
      jump_latch <= 1'b0;
      prev_btn   <= 1'b0;
`ifdef DOUBLE_JUMP_EN
      jump_cnt   <= 1'b0;
`endif
    end else begin
      state      <= state_nxt;
      y_pos      <= y_nxt;
      vel_y      <= vel_nxt;
      jump_latch <= latch_nxt;
      prev_btn   <= jump_btn;
`ifdef DOUBLE_JUMP_EN
      jump_cnt   <= cnt_nxt;
`endif
    end
  end

endmodule

// File: tb/tb_vertical_motion.sv
// Directed bench for vertical_motion: vector table for jump/landing/clamp steps plus fall, double-jump and reset sequences.
module tb_vertical_motion;

  logic              clk = 1'b0;
  logic              rst;
  logic              frame_tick;
  logic              jump_btn;
  logic              touching_platform;
  logic [9:0]        land_y;
  logic              supported;
  logic [9:0]        y_pos;
  logic [9:0]        next_y;
  logic signed [5:0] vel_y;
  logic              airborne;

  int n_vec = 0;
  int n_bad = 0;

  typedef struct {
    bit tick;
    bit btn;
    bit touch;
    int land;
    bit sup;
    int y;
    int v;
    bit air;
  } vec_t;

  vec_t vecs[32];

  vertical_motion dut (
    .clk               (clk),
    .rst               (rst),
    .frame_tick        (frame_tick),
    .jump_btn          (jump_btn),
    .touching_platform (touching_platform),
    .land_y            (land_y),
    .supported         (supported),
    .y_pos             (y_pos),
    .next_y            (next_y),
    .vel_y             (vel_y),
    .airborne          (airborne)
  );

  always #5 clk = ~clk;

  function automatic vec_t mk(bit t, bit b, bit tp, int ly, bit s, int y, int v, bit a);
    vec_t r;
    r.tick = t; r.btn = b; r.touch = tp; r.land = ly; r.sup = s;
    r.y = y; r.v = v; r.air = a;
    return r;
  endfunction

  task automatic chk(input string nm, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: actual %0d, required %0d", nm, act, exp);
    end
  endtask

  task automatic check_out(input string tag, input int y, input int v, input bit a);
    chk({tag, "_y"},   int'(y_pos), y);
    chk({tag, "_vel"}, int'(vel_y), v);
    chk({tag, "_air"}, int'(airborne), int'(a));
  endtask

  // Drive one cycle's inputs, clock once, and return 1 time unit after the edge.
  task automatic do_cycle(input bit t, input bit b, input bit tp, input int ly, input bit s);
    frame_tick        = t;
    jump_btn          = b;
    touching_platform = tp;
    land_y            = 10'(ly);
    supported         = s;
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ye, ve;
    bit ae;

    vecs[0]  = mk(0, 1, 0, 0,   1, 380,   0, 0);
    vecs[1]  = mk(0, 0, 0, 0,   1, 380,   0, 0);
    vecs[2]  = mk(0, 1, 0, 0,   1, 380,   0, 0);
    vecs[3]  = mk(1, 1, 0, 0,   1, 380, -12, 1);
    vecs[4]  = mk(1, 0, 0, 0,   1, 368, -11, 1);
    vecs[5]  = mk(1, 0, 1, 100, 1, 357, -10, 1);
    vecs[6]  = mk(0, 0, 0, 0,   1, 357, -10, 1);
    vecs[7]  = mk(1, 0, 0, 0,   1, 347,  -9, 1);
    vecs[8]  = mk(1, 0, 0, 0,   1, 338,  -8, 1);
    vecs[9]  = mk(1, 0, 0, 0,   1, 330,  -7, 1);
    vecs[10] = mk(1, 0, 0, 0,   1, 323,  -6, 1);
    vecs[11] = mk(1, 0, 0, 0,   1, 317,  -5, 1);
    vecs[12] = mk(1, 0, 0, 0,   1, 312,  -4, 1);
    vecs[13] = mk(1, 0, 0, 0,   1, 308,  -3, 1);
    vecs[14] = mk(1, 0, 0, 0,   1, 305,  -2, 1);
    vecs[15] = mk(1, 0, 0, 0,   1, 303,  -1, 1);
    vecs[16] = mk(1, 0, 0, 0,   1, 302,   0, 1);
    vecs[17] = mk(1, 0, 0, 0,   1, 302,   1, 1);
    vecs[18] = mk(1, 0, 0, 0,   1, 303,   2, 1);
    vecs[19] = mk(1, 0, 0, 0,   1, 305,   3, 1);
    vecs[20] = mk(1, 0, 0, 0,   1, 308,   4, 1);
    vecs[21] = mk(1, 0, 1, 215, 1, 155,   0, 0);
    vecs[22] = mk(1, 0, 0, 0,   1, 155,   0, 0);
    vecs[23] = mk(1, 0, 0, 0,   0, 155,   1, 1);
    vecs[24] = mk(1, 0, 0, 0,   0, 156,   2, 1);
    vecs[25] = mk(1, 0, 1, 215, 0, 155,   0, 0);
    vecs[26] = mk(1, 0, 0, 0,   0, 155,   1, 1);
    vecs[27] = mk(1, 0, 1, 60,  1,   0,   0, 0);
    vecs[28] = mk(0, 1, 0, 0,   1,   0,   0, 0);
    vecs[29] = mk(1, 0, 0, 0,   1,   0, -12, 1);
    vecs[30] = mk(1, 0, 0, 0,   1,   0,   0, 1);
    vecs[31] = mk(1, 0, 0, 0,   1,   0,   1, 1);

    // Reset and idle
    rst = 1'b1;
    frame_tick = 1'b0; jump_btn = 1'b0; touching_platform = 1'b0;
    land_y = '0; supported = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check_out("reset", 380, 0, 0);
    chk("reset_next_y", int'(next_y), 380);
    rst = 1'b0;
    for (int i = 0; i < 10; i++) begin
      do_cycle(1, 0, 0, 0, 1);
      check_out($sformatf("idle%0d", i), 380, 0, 0);
    end

    // Vector table: jump, rise through a platform, land on platforms, walk off, ceiling clamp
    for (int i = 0; i < 32; i++) begin
      do_cycle(vecs[i].tick, vecs[i].btn, vecs[i].touch, vecs[i].land, vecs[i].sup);
      check_out($sformatf("vec%0d", i), vecs[i].y, vecs[i].v, vecs[i].air);
    end

    // Long fall from the top row: velocity saturates, floor clamps
    ye = 0; ve = 1; ae = 1'b1;
    for (int i = 0; i < 60 && ae; i++) begin
      chk($sformatf("fall%0d_next_y", i), int'(next_y), (ye + ve > 380) ? 380 : ye + ve);
      do_cycle(1, 0, 0, 0, 1);
      if (ye + ve >= 380) begin
        ye = 380; ve = 0; ae = 1'b0;
      end else begin
        ye = ye + ve;
        ve = (ve + 1 > 10) ? 10 : ve + 1;
      end
      check_out($sformatf("fall%0d", i), ye, ve, ae);
      chk($sformatf("fall%0d_vmax", i), int'(int'(vel_y) <= 10), 1);
    end

    // Two jump edges 20 ticks apart
    do_cycle(0, 1, 0, 0, 1);
    do_cycle(1, 0, 0, 0, 1);
    check_out("dj_launch", 380, -12, 1);
    repeat (19) do_cycle(1, 0, 0, 0, 1);
    check_out("dj_before", 323, 7, 1);
    do_cycle(0, 1, 0, 0, 1);
    do_cycle(1, 0, 0, 0, 1);
`ifdef DOUBLE_JUMP_EN
    check_out("dj_second", 330, -12, 1);
    do_cycle(1, 0, 0, 0, 1);
    check_out("dj_after", 318, -11, 1);
`else
    check_out("dj_second", 330, 8, 1);
    do_cycle(1, 0, 0, 0, 1);
    check_out("dj_after", 338, 9, 1);
`endif
    for (int i = 0; i < 80; i++) begin
      if (!airborne) break;
      do_cycle(1, 0, 0, 0, 1);
    end
    check_out("dj_landed", 380, 0, 0);
    repeat (3) do_cycle(1, 0, 0, 0, 1);
    check_out("dj_settled", 380, 0, 0);

    // Reset mid-jump overrides a simultaneous tick
    do_cycle(0, 1, 0, 0, 1);
    do_cycle(1, 0, 0, 0, 1);
    do_cycle(1, 0, 0, 0, 1);
    check_out("rj_air", 368, -11, 1);
    rst = 1'b1;
    do_cycle(1, 0, 0, 0, 1);
    check_out("rj_reset", 380, 0, 0);
    rst = 1'b0;
    do_cycle(1, 0, 0, 0, 1);
    check_out("rj_after", 380, 0, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
